// File: rtl/sce_counter_pkg.sv
// Shared types and the half-word thermometer decode used by the count expander.
package sce_counter_pkg;

    localparam int N_BITS_DEF = 32;
    localparam int CNT_W_DEF  = 6;
    localparam int HALF_W     = 16;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Bit j is set when the count reaches past position base+j.
    function automatic logic [HALF_W-1:0] therm_of(cnt_t c, int base);
        logic [HALF_W-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < HALF_W; j++) begin
            r[j] = (int'(c) > (base + int'(j)));
        end
        return r;
    endfunction

endpackage

// File: rtl/count_to_thermometer_expander_half_decode.sv
// Combinational decode of one 16-bit slice of the thermometer word, offset by BASE.
module therm_half_decode
    import sce_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int BASE  = 0
) (
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [HALF_W-1:0] half_o
);

    always_comb begin
        half_o = therm_of(cnt_t'(cnt_i), BASE);
    end

endmodule

// File: rtl/count_to_thermometer_expander.sv
// Three-stage count-to-thermometer expander with a global-stall valid/ready pipeline.
module count_to_thermometer_expander
    import sce_counter_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_therm,
    output logic              out_ovf
);

    if (STAGES != 3 || CNT_W != $clog2(N_BITS + 1) || N_BITS != 2 * HALF_W) begin : g_param_check
        $error("count_to_thermometer_expander: unsupported parameter combination");
    end

    logic              adv;
    logic              v1_d, ovf1_d;
    logic [CNT_W-1:0]  cnt1_d;
    logic [HALF_W-1:0] lo_d, hi_d;

    logic              v1_q, ovf1_q;
    logic [CNT_W-1:0]  cnt1_q;
    logic              v2_q, ovf2_q;
    logic [HALF_W-1:0] lo2_q, hi2_q;
    logic              v3_q, ovf3_q;
    logic [N_BITS-1:0] therm3_q;

    // Whole pipeline moves as one unit whenever the output slot is free or draining.
    always_comb begin
        adv      = ~v3_q | out_ready;
        in_ready = adv & ~rst;
    end

    always_comb begin
        ovf1_d = (int'(in_count) > N_BITS);
        cnt1_d = ovf1_d ? CNT_W'(N_BITS) : in_count;
        v1_d   = in_valid & in_ready;
    end

    therm_half_decode #(.CNT_W(CNT_W), .BASE(0)) u_lo (
        .cnt_i  (cnt1_q),
        .half_o (lo_d)
    );

    therm_half_decode #(.CNT_W(CNT_W), .BASE(HALF_W)) u_hi (
        .cnt_i  (cnt1_q),
        .half_o (hi_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            therm3_q <= '0;
            ovf3_q   <= 1'b0;
        end else if (adv) begin
            v1_q     <= v1_d;
            cnt1_q   <= cnt1_d;
            ovf1_q   <= ovf1_d;
            v2_q     <= v1_q;
            lo2_q    <= lo_d;
            hi2_q    <= hi_d;
            ovf2_q   <= ovf1_q;
            v3_q     <= v2_q;
            therm3_q <= {hi2_q, lo2_q};
            ovf3_q   <= ovf2_q;
        end
    end

    always_comb begin
        out_valid = v3_q;
        out_therm = therm3_q;
        out_ovf   = ovf3_q;
    end

endmodule

// File: tb/tb_count_to_thermometer_expander.sv
// Scoreboard bench for the count-to-thermometer expander.
module tb_count_to_thermometer_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_therm;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;
    logic [5:0]  sb[$];
    bit          rnd_ready = 1'b0;
    bit          hold_q = 1'b0;
    logic [32:0] held_q = '0;

    count_to_thermometer_expander #(.N_BITS(32), .CNT_W(6), .STAGES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_therm (out_therm),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [5:0] c);
        int          s;
        logic [63:0] t;
        s = (c > 6'd32) ? 32 : int'(c);
        t = (64'd1 << s) - 64'd1;
        return {(c > 6'd32), t[31:0]};
    endfunction

    // Monitor: scoreboard push on accept, pop/compare on output transfer, hold check on stall.
    always @(negedge clk) begin
        if (hold_q) check("hold", {31'd0, out_valid, out_ovf, out_therm}, {31'd0, 1'b1, held_q});
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    check("therm", {32'd0, out_therm}, {32'd0, model(sb[0])} & 64'hFFFF_FFFF);
                    check("ovf", {63'd0, out_ovf}, {63'd0, model(sb[0])} >> 32);
                    if (rnd_ready)
                        check("popcount", 64'($countones(out_therm)), (sb[0] > 6'd32) ? 64'd32 : {58'd0, sb[0]});
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(in_count);
        end
        hold_q <= out_valid && !out_ready && !rst;
        held_q <= {out_ovf, out_therm};
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [5:0] c);
        int n;
        in_valid = 1'b1;
        in_count = c;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            cycle();
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        cycle();
        cycle();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_count  = '0;
        out_ready = 1'b1;
        cycle();
        cycle();
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_therm", {32'd0, out_therm}, 64'd0);
        check("rst_ovf", {63'd0, out_ovf}, 64'd0);
        rst = 1'b0;
        cycle();
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);

        // Latency: accept on edge 1, visible after edge 3.
        send(6'd0);
        check("lat_e1", {63'd0, out_valid}, 64'd0);
        cycle();
        check("lat_e2", {63'd0, out_valid}, 64'd0);
        cycle();
        check("lat_e3", {63'd0, out_valid}, 64'd1);
        check("zero_therm", {32'd0, out_therm}, 64'd0);
        drain();

        send(6'd1); send(6'd16); send(6'd17); send(6'd32);
        drain();

        send(6'd45); send(6'd5); send(6'd33); send(6'd63);
        drain();

        // Fill while the consumer stalls, then release.
        out_ready = 1'b0;
        send(6'd3); send(6'd7); send(6'd9);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_therm", {32'd0, out_therm}, 64'h7);
            cycle();
        end
        out_ready = 1'b1;
        drain();

        // Reset with two words in flight.
        send(6'd10); send(6'd20);
        rst = 1'b1;
        cycle();
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("flush_quiet", {63'd0, out_valid}, 64'd0);
        end
        send(6'd12);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) cycle();
            else send(6'($urandom_range(0, 63)));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
